ps2_kbd: RTL and testbench
==========================

# ps2_kbd

PS/2 keyboard receiver with a scan-code FIFO, exposed as a memory-mapped read peripheral on the CPU data bus. It samples the raw `PS2_CLK`/`PS2_DAT` board pins, deframes 11-bit PS/2 frames and buffers the received bytes. The MMU reads them through `dout_kbd` when `sel_kbd` is active. The block is the producer that feeds the MMU's keyboard read path.

## Interface
- `FIFO_DEPTH`, 8 — scan-code FIFO entries; power of two, from 2 to 256.
- `TIMEOUT_CYCLES`, 20000 — number of `clock` cycles with no PS/2 falling edge, while mid-frame, before the frame is aborted.
- `clock` in 1 — system clock (the CPU data-read clock domain).
- `reset` in 1 — synchronous, active-low.
- `ps2_clk` in 1 — raw PS/2 clock pin; asynchronous.
- `ps2_dat` in 1 — raw PS/2 data pin; asynchronous.
- `sel` in 1 — address decode hit for this peripheral.
- `re` in 1 — data read strobe.
- `addr` in 32 — bus address; only bit 2 is decoded.
- `dout` out 32 — read data; combinational.

## Operation
- **Input synchronization:** two-flop synchronizer on each pin, followed by one history flop on the clock. A falling edge is detected when the history flop is 1 and the synchronized clock is 0.
- **Receive FSM states:** IDLE, DATA, PARITY, STOP. The FSM acts only on detected falling edges, except for timeout.
  - IDLE: if dat=0, clear the shift register and bit counter, then go to DATA. If dat=1, stay in IDLE (the edge is ignored).
  - DATA: shift dat in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: latch dat as the parity bit, go to STOP.
  - STOP: the frame is good if the XOR of the 8 data bits and the parity bit is 1, and stop=1. Good frame: push the byte. Bad frame: set `frame_err` and drop the byte. Either way, return to IDLE.
- **Timeout:** a counter clears on every detected falling edge and in IDLE. Outside IDLE, when it reaches TIMEOUT_CYCLES-1: go to IDLE, set `frame_err`, discard the partial byte.
- **FIFO:** circular buffer with read and write pointers and a count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- **Register map (addr[2]):**
  - 0 — DATA register: `dout` = {23'b0, nonempty, head_byte}. With the FIFO empty it reads 0.
  - 1 — STATUS register: `dout` = {16'b0, count[7:0], 5'b0, frame_err, overflow, nonempty}.
- **When sel=0:** `dout` = 0.
- **Pop:** each clock edge with sel & re & ~addr[2] & nonempty pops one entry. A pop on an empty FIFO is a no-op.
- **Status read:** each clock edge with sel & re & addr[2] clears `overflow` and `frame_err`.
- **Push when full:**
  - With a pop on the same edge: the push is accepted and count stays at FIFO_DEPTH.
  - Without a pop: the byte is dropped and `overflow` is set.
- **Push and pop on the same edge (not full):** both happen and count is unchanged.
- **Sticky clear versus new event on the same edge:** the set wins and the bit reads 1 afterwards.

## Timing
- **Reset values** (when reset=0 at an edge):
  - FSM in IDLE.
  - Pointers, count, `overflow`, `frame_err`, timeout counter and shift register all 0.
  - Synchronizer and history flops at 1 (bus-idle level).
  - `dout` reads 0 for both registers.
- **Reset mid-frame:** the partial frame is discarded. The next falling edge is treated as a start-bit candidate.
- **Edge latency:** a raw `ps2_clk` fall is acted on at the 3rd rising `clock` edge after the transition (±1 for metastability). `ps2_dat` passes through an identical path, so it is sampled aligned with the clock.
- **Push visibility:** the byte is pushed on the edge that processes the stop-bit falling edge. `nonempty`, the head byte and count are visible on `dout` in the following cycle.
- **Pop latency:** after a pop edge, `dout` shows the next entry (or 0) combinationally in the following cycle.
- **Pop rate:** one pop per asserted cycle. A `re` held for N cycles pops up to N entries.
- **Design assumption:** PS/2 bit period 60–100 µs, so an edge is seen every 600 or more clocks at 10 MHz. No debounce beyond the synchronizer.

## Test plan
- **Good frame:** after reset, send a frame for 0x1C with parity=0 and stop=1.
  - DATA read returns 0x0000011C.
  - STATUS read before the pop returns 0x00000101.
  - A second DATA read returns 0x00000000.
- **Parity error:** send 0x1C with parity=1. STATUS returns 0x00000004 (no push). The next STATUS read returns 0x00000000.
- **Overflow:** with FIFO_DEPTH=8, send bytes 0x01–0x09 without reading.
  - STATUS returns 0x00000803.
  - Eight DATA reads return 0x101–0x108 in order; 0x09 is lost.
  - A ninth DATA read returns 0.
- **Timeout then recovery:** send a start bit plus 3 data bits, then idle for TIMEOUT_CYCLES+5 clocks.
  - STATUS returns 0x00000004.
  - A following complete frame for 0xF0 (parity=1) reads back as 0x000001F0.
- **Full FIFO with simultaneous pop:** fill the FIFO to 8 entries. Align a DATA read with the stop-bit edge of a 9th byte 0xAA. Count stays 8, `overflow` stays 0, and 0xAA is the last entry read.
- **Reset mid-frame:** pulse reset=0 for one cycle after 5 data bits. A subsequent frame for 0x5A (parity=1) yields exactly one entry, 0x15A, and STATUS shows no errors.

Source files
------------

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: pin synchronizers, 11-bit frame deframer with timeout,
// and a scan-code FIFO read through a two-register memory-mapped window.
module ps2_kbd #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic        sel,
    input  logic        re,
    input  logic [31:0] addr,
    output logic [31:0] dout
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data; both idle high.
    logic [1:0] sync1_reg, sync2_reg;
    logic       clk_hist_reg;
    logic       fall, dat;

    state_t         state_reg, state_next;
    logic [7:0]     shift_reg, shift_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic           parity_reg, parity_next;
    logic [TW-1:0]  tmo_reg, tmo_next;
    logic           push, frame_evt;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           overflow_reg, frame_err_reg;
    logic           nonempty, full, pop, stat_rd, push_ok, ovf_evt;
    logic [7:0]     count_lo;
    logic           unused_addr;

    assign unused_addr = ^{addr[31:3], addr[1:0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_reg    <= 2'b11;
            sync2_reg    <= 2'b11;
            clk_hist_reg <= 1'b1;
        end else begin
            sync1_reg    <= {ps2_dat, ps2_clk};
            sync2_reg    <= sync1_reg;
            clk_hist_reg <= sync2_reg[0];
        end
    end

    assign fall = clk_hist_reg & ~sync2_reg[0];
    assign dat  = sync2_reg[1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            parity_reg  <= 1'b0;
            tmo_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            parity_reg  <= parity_next;
            tmo_reg     <= tmo_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        parity_next  = parity_reg;
        tmo_next     = tmo_reg + 1'b1;
        push         = 1'b0;
        frame_evt    = 1'b0;
        if (state_reg == IDLE) tmo_next = '0;
        if (fall) begin
            tmo_next = '0;
            case (state_reg)
                IDLE: begin
                    if (!dat) begin
                        shift_next   = '0;
                        bit_cnt_next = '0;
                        state_next   = DATA;
                    end
                end
                DATA: begin
                    shift_next   = {dat, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) state_next = PARITY;
                end
                PARITY: begin
                    parity_next = dat;
                    state_next  = STOP;
                end
                STOP: begin
                    // Odd parity over data+parity, plus a high stop bit.
                    if ((^shift_reg ^ parity_reg) && dat) push = 1'b1;
                    else frame_evt = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
            frame_evt  = 1'b1;
            shift_next = '0;
            tmo_next   = '0;
        end
    end

    assign nonempty = (count_reg != '0);
    assign full     = (count_reg == CW'(FIFO_DEPTH));
    assign pop      = sel & re & ~addr[2] & nonempty;
    assign stat_rd  = sel & re & addr[2];
    assign push_ok  = push & (~full | pop);
    assign ovf_evt  = push & full & ~pop;
    assign count_lo = 8'(count_reg);

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // A new event on the same edge as a status read keeps the bit set.
            if (ovf_evt)      overflow_reg <= 1'b1;
            else if (stat_rd) overflow_reg <= 1'b0;
            if (frame_evt)    frame_err_reg <= 1'b1;
            else if (stat_rd) frame_err_reg <= 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        if (sel) begin
            if (addr[2])
                dout = {16'b0, count_lo, 5'b0, frame_err_reg, overflow_reg, nonempty};
            else if (nonempty)
                dout = {23'b0, 1'b1, mem[rd_ptr_reg]};
        end
    end

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: bit-banged PS/2 frames, a byte scoreboard and a
// small status model supply every expected bus read value.
module tb_ps2_kbd;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;
    localparam int HALF  = 20;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        sel     = 1'b0;
    logic        re      = 1'b0;
    logic [31:0] addr    = '0;
    logic [31:0] dout;

    int tests = 0;
    int fails = 0;
    byte unsigned expq[$];
    bit m_ovf  = 1'b0;
    bit m_ferr = 1'b0;

    ps2_kbd #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .sel     (sel),
        .re      (re),
        .addr    (addr),
        .dout    (dout)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        $display("[TB] %s: dout=%08h expected=%08h", tag, obs, want);
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {16'b0, 8'(expq.size()), 5'b0, m_ferr, m_ovf, expq.size() != 0};
    endfunction

    // One read strobe held for exactly one rising edge.
    task automatic bus_read(input bit is_status, input string tag);
        logic [31:0] want;
        @(negedge clock);
        sel = 1'b1; re = 1'b1; addr = is_status ? 32'h4 : 32'h0;
        #1;
        if (is_status) begin
            want = status_exp();
            m_ovf = 1'b0; m_ferr = 1'b0;
        end else if (expq.size() != 0) begin
            want = {23'b0, 1'b1, expq.pop_front()};
        end else begin
            want = '0;
        end
        check(tag, dout, want);
        @(negedge clock);
        sel = 1'b0; re = 1'b0;
    endtask

    // With align set, a DATA read lands on the edge that acts on this fall.
    task automatic send_bit(input bit b, input bit align = 1'b0);
        ps2_dat = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        if (align) begin
            @(negedge clock);
            bus_read(1'b0, "pop_at_stop_edge");
            repeat (HALF - 3) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input byte unsigned d, input bit par, input bit align = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1, align);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
        if ((^d) ^ par) begin
            if (expq.size() >= DEPTH) m_ovf = 1'b1;
            else expq.push_back(d);
        end else begin
            m_ferr = 1'b1;
        end
        $display("[TB] sent frame %02h parity=%0b", d, par);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        sel = 1'b1; addr = 32'h0; #1;
        check("reset_data", dout, 32'h0);
        addr = 32'h4; #1;
        check("reset_status", dout, 32'h0);
        sel = 1'b0;

        // Good frame
        send_frame(8'h1C, 1'b0);
        @(negedge clock);
        sel = 1'b0; addr = 32'h0; #1;
        check("sel_low_zero", dout, 32'h0);
        bus_read(1'b1, "good_status");
        bus_read(1'b0, "good_data");
        bus_read(1'b0, "good_data_empty");

        // Parity error
        send_frame(8'h1C, 1'b1);
        bus_read(1'b1, "parity_status");
        bus_read(1'b1, "parity_status_cleared");

        // Overflow
        for (int i = 1; i <= 9; i++) send_frame(8'(i), ~^(8'(i)));
        bus_read(1'b1, "ovf_status");
        for (int i = 0; i < 9; i++) bus_read(1'b0, $sformatf("ovf_data%0d", i));
        bus_read(1'b1, "ovf_status_after");

        // Timeout mid-frame, then recovery
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (TMO + 5) @(negedge clock);
        m_ferr = 1'b1;
        bus_read(1'b1, "timeout_status");
        send_frame(8'hF0, 1'b1);
        bus_read(1'b0, "recover_data");
        bus_read(1'b1, "recover_status");

        // Full FIFO with a pop on the stop-bit edge
        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), ~^(8'(8'h10 + i)));
        send_frame(8'hAA, 1'b1, 1'b1);
        bus_read(1'b1, "full_pop_status");
        for (int i = 0; i < DEPTH + 1; i++) bus_read(1'b0, $sformatf("full_pop_data%0d", i));

        // Reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        expq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
        send_frame(8'h5A, 1'b1);
        bus_read(1'b1, "midreset_status");
        bus_read(1'b0, "midreset_data");
        bus_read(1'b0, "midreset_empty");
        bus_read(1'b1, "midreset_status_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
